sri_dmi_bridge: RTL and testbench

Memory-mapped DMI master. Lets a system-bus agent (via the `axilite_to_sri` SRI output) issue DMI read/write transactions to `riscv_dm`, as an alternative to the JTAG DTM. Sits between an SRI slave port and a DMI request/response arbiter feeding the debug module. Operates as a two-register mailbox with a single-outstanding-transaction FSM, busy/sticky-error reporting and an optional response timeout.

---
 rtl/sri_dmi_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_sri_dmi_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sri_dmi_bridge.sv
// Memory-mapped DMI master: CMD/STATUS mailbox driving one DMI transaction at a time.
// Optional response timeout and late-response drain enabled by `define SRI_DMI_TIMEOUT_EN.
module sri_dmi_bridge #(
  parameter int SRI_ADDR_WIDTH = 4,
  parameter int SRI_DATA_WIDTH = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DMI_ADDR_WIDTH = 7,
  localparam int DMI_DATA_WIDTH = 32,
  localparam int DMI_OP_WIDTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [SRI_ADDR_WIDTH-1:0] sri_addr_i,
  input  logic                      sri_en_i,
  input  logic                      sri_we_i,
  input  logic [SRI_DATA_WIDTH-1:0] sri_wdata_i,
  input  logic [7:0]                sri_be_i,
  output logic [SRI_DATA_WIDTH-1:0] sri_rdata_o,
  output logic                      sri_error_o,
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output logic [DMI_ADDR_WIDTH-1:0] req_addr_o,
  output logic [DMI_DATA_WIDTH-1:0] req_data_o,
  output logic [DMI_OP_WIDTH-1:0]   req_op_o,
  input  logic                      resp_valid_i,
  output logic                      resp_ready_o,
  input  logic [DMI_DATA_WIDTH-1:0] resp_data_i,
  input  logic [DMI_OP_WIDTH-1:0]   resp_op_i
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  localparam int WORD_W = SRI_ADDR_WIDTH - 3;
  localparam logic [WORD_W-1:0] W_CMD    = '0;
  localparam logic [WORD_W-1:0] W_STATUS = WORD_W'(1);

  state_e                    state_q, state_d;
  logic                      req_valid_q, req_valid_d;
  logic                      resp_ready_q, resp_ready_d;
  logic [DMI_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DMI_DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic [DMI_OP_WIDTH-1:0]   req_op_q, req_op_d;
  logic [DMI_DATA_WIDTH-1:0] last_data_q, last_data_d;
  logic [DMI_OP_WIDTH-1:0]   last_op_q, last_op_d;
  logic                      busyerr_q, busyerr_d;
  logic                      rvalid_q, rvalid_d;
  logic [SRI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      error_q, error_d;

  logic                      timeout_flag, drain_pending, busy, resp_fire;
  logic [WORD_W-1:0]         word;
  logic [1:0]                cmd_op;
  logic [63:0]               status_word;
  logic                      unused_bits;

`ifdef SRI_DMI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic             timeout_q, timeout_d;
  logic             drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign timeout_flag  = timeout_q;
  assign drain_pending = drain_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_flag  = 1'b0;
  assign drain_pending = 1'b0;
`endif

  assign word        = sri_addr_i[SRI_ADDR_WIDTH-1:3];
  assign cmd_op      = sri_wdata_i[41:40];
  assign busy        = (state_q != S_IDLE) | drain_pending;
  assign resp_fire   = resp_valid_i & resp_ready_q;
  assign status_word = {20'b0, timeout_flag, rvalid_q, busyerr_q, busy, 6'b0, last_op_q, last_data_q};
  assign unused_bits = ^{sri_wdata_i, sri_be_i, sri_addr_i[2:0]};

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_op_d    = req_op_q;
    last_data_d = last_data_q;
    last_op_d   = last_op_q;
    busyerr_d   = busyerr_q;
    rvalid_d    = rvalid_q;
    rdata_d     = '0;
    error_d     = 1'b0;
`ifdef SRI_DMI_TIMEOUT_EN
    timeout_d   = timeout_q;
    drain_d     = drain_q;
    cnt_d       = cnt_q;
`endif

    // Register access is resolved first so that hardware flag events below win over a clear.
    if (sri_en_i) begin
      if (word == W_CMD) begin
        if (sri_we_i) begin
          if (busy) begin
            busyerr_d = 1'b1;
            error_d   = 1'b1;
          end else if (sri_be_i[5:0] != 6'h3F || !(cmd_op == 2'd1 || cmd_op == 2'd2)) begin
            error_d = 1'b1;
          end else begin
            req_data_d = sri_wdata_i[31:0];
            req_addr_d = sri_wdata_i[32 +: DMI_ADDR_WIDTH];
            req_op_d   = cmd_op;
            rvalid_d   = 1'b0;
            state_d    = S_REQ;
          end
        end
      end else if (word == W_STATUS) begin
        if (sri_we_i) begin
          if (sri_be_i[5]) begin
            if (sri_wdata_i[41]) busyerr_d = 1'b0;
`ifdef SRI_DMI_TIMEOUT_EN
            if (sri_wdata_i[43]) timeout_d = 1'b0;
`endif
          end
        end else begin
          rdata_d = status_word;
        end
      end else begin
        error_d = 1'b1;
      end
    end

    case (state_q)
      S_REQ: begin
        if (req_ready_i) begin
          state_d = S_WAIT;
`ifdef SRI_DMI_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      S_WAIT: begin
        if (resp_fire) begin
          last_data_d = resp_data_i;
          last_op_d   = resp_op_i;
          rvalid_d    = 1'b1;
          state_d     = S_IDLE;
        end
`ifdef SRI_DMI_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          last_op_d = 2'b10;
          rvalid_d  = 1'b1;
          drain_d   = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
`ifdef SRI_DMI_TIMEOUT_EN
        // The response that eventually arrives for a timed-out request is swallowed here.
        if (drain_q && resp_fire) drain_d = 1'b0;
`endif
      end
    endcase

    req_valid_d  = (state_d == S_REQ);
`ifdef SRI_DMI_TIMEOUT_EN
    resp_ready_d = (state_d == S_WAIT) | ((state_d == S_IDLE) & drain_d);
`else
    resp_ready_d = (state_d == S_WAIT);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_op_q     <= '0;
      last_data_q  <= '0;
      last_op_q    <= '0;
      busyerr_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
`ifdef SRI_DMI_TIMEOUT_EN
      timeout_q    <= 1'b0;
      drain_q      <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      resp_ready_q <= resp_ready_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_op_q     <= req_op_d;
      last_data_q  <= last_data_d;
      last_op_q    <= last_op_d;
      busyerr_q    <= busyerr_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
`ifdef SRI_DMI_TIMEOUT_EN
      timeout_q    <= timeout_d;
      drain_q      <= drain_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign sri_rdata_o  = rdata_q;
  assign sri_error_o  = error_q;
  assign req_valid_o  = req_valid_q;
  assign resp_ready_o = resp_ready_q;
  assign req_addr_o   = req_addr_q;
  assign req_data_o   = req_data_q;
  assign req_op_o     = req_op_q;
endmodule

// File: tb/tb_sri_dmi_bridge.sv
// Scoreboard bench for sri_dmi_bridge: SRI responses and DMI requests are checked by
// monitors against queues filled by the directed stimulus.
module tb_sri_dmi_bridge;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  sri_addr_i;
  logic        sri_en_i, sri_we_i;
  logic [63:0] sri_wdata_i;
  logic [7:0]  sri_be_i;
  logic [63:0] sri_rdata_o;
  logic        sri_error_o;
  logic        req_valid_o, req_ready_i;
  logic [6:0]  req_addr_o;
  logic [31:0] req_data_o;
  logic [1:0]  req_op_o;
  logic        resp_valid_i, resp_ready_o;
  logic [31:0] resp_data_i;
  logic [1:0]  resp_op_i;

  sri_dmi_bridge #(.SRI_ADDR_WIDTH(5), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sri_addr_i(sri_addr_i), .sri_en_i(sri_en_i), .sri_we_i(sri_we_i),
    .sri_wdata_i(sri_wdata_i), .sri_be_i(sri_be_i),
    .sri_rdata_o(sri_rdata_o), .sri_error_o(sri_error_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_op_o(req_op_o),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
    .resp_data_i(resp_data_i), .resp_op_i(resp_op_i)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  logic [63:0] exp_rdata_q[$];
  logic        exp_err_q[$];
  string       exp_name_q[$];
  logic [6:0]  exp_raddr_q[$];
  logic [31:0] exp_rdat_q[$];
  logic [1:0]  exp_rop_q[$];
  bit          en_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // SRI monitor: an access at one edge is answered in the following cycle
  always @(posedge clk_i) en_seen <= sri_en_i && !rst_i;

  always @(negedge clk_i) begin
    if (en_seen) begin
      if (exp_name_q.size() == 0) begin
        check("sri_unexpected_resp", 64'd1, 64'd0);
      end else begin
        string nm;
        logic [63:0] er;
        logic ee;
        nm = exp_name_q.pop_front();
        er = exp_rdata_q.pop_front();
        ee = exp_err_q.pop_front();
        check({nm, "_rdata"}, sri_rdata_o, er);
        check({nm, "_err"}, {63'd0, sri_error_o}, {63'd0, ee});
      end
    end
    if (req_valid_o && req_ready_i && !rst_i) begin
      if (exp_raddr_q.size() == 0) begin
        check("dmi_unexpected_req", 64'd1, 64'd0);
      end else begin
        check("dmi_req_addr", {57'd0, req_addr_o}, {57'd0, exp_raddr_q.pop_front()});
        check("dmi_req_data", {32'd0, req_data_o}, {32'd0, exp_rdat_q.pop_front()});
        check("dmi_req_op", {62'd0, req_op_o}, {62'd0, exp_rop_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic sri_wr(input string nm, input int w, input logic [63:0] d,
                        input logic [7:0] be, input logic err);
    sri_en_i = 1'b1; sri_we_i = 1'b1; sri_addr_i = 5'(w * 8);
    sri_wdata_i = d; sri_be_i = be;
    exp_name_q.push_back(nm); exp_rdata_q.push_back(64'd0); exp_err_q.push_back(err);
    cyc();
    sri_en_i = 1'b0; sri_we_i = 1'b0;
  endtask

  task automatic sri_rd(input string nm, input int w, input logic [63:0] exp_d, input logic err);
    sri_en_i = 1'b1; sri_we_i = 1'b0; sri_addr_i = 5'(w * 8); sri_be_i = 8'hFF;
    exp_name_q.push_back(nm); exp_rdata_q.push_back(exp_d); exp_err_q.push_back(err);
    cyc();
    sri_en_i = 1'b0;
  endtask

  task automatic cmd_ok(input string nm, input logic [1:0] op, input logic [6:0] a,
                        input logic [31:0] d);
    exp_raddr_q.push_back(a); exp_rdat_q.push_back(d); exp_rop_q.push_back(op);
    sri_wr(nm, 0, {22'd0, op, 1'b0, a, d}, 8'hFF, 1'b0);
  endtask

  task automatic do_resp(input string nm, input logic [31:0] d, input logic [1:0] op);
    bit hs;
    hs = 1'b0;
    resp_valid_i = 1'b1; resp_data_i = d; resp_op_i = op;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = resp_ready_o;
      cyc();
    end
    resp_valid_i = 1'b0;
    check({nm, "_handshake"}, {63'd0, hs}, 64'd1);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_req_valid"}, {63'd0, req_valid_o}, 64'd0);
    check({nm, "_resp_ready"}, {63'd0, resp_ready_o}, 64'd0);
    check({nm, "_rdata"}, sri_rdata_o, 64'd0);
    check({nm, "_err"}, {63'd0, sri_error_o}, 64'd0);
    check({nm, "_payload"}, {23'd0, req_addr_o, req_data_o, req_op_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; sri_en_i = 1'b0; sri_we_i = 1'b0; sri_addr_i = '0;
    sri_wdata_i = '0; sri_be_i = '0; req_ready_i = 1'b0;
    resp_valid_i = 1'b0; resp_data_i = '0; resp_op_i = '0;
    repeat (3) cyc();
    check_all_zero("reset");
    rst_i = 1'b0;
    cyc();
    sri_rd("status_after_reset", 1, 64'd0, 1'b0);

    // Basic read transaction with ready held high
    req_ready_i = 1'b1;
    cmd_ok("cmd_read_11", 2'd1, 7'h11, 32'd0);
    check("req_valid_rise", {63'd0, req_valid_o}, 64'd1);
    cyc();
    do_resp("resp1", 32'h0000_0C82, 2'd0);
    sri_rd("status1", 1, 64'h0000_0400_0000_0C82, 1'b0);
    sri_rd("cmd_reads_zero", 0, 64'd0, 1'b0);

    // Write with ready withheld for five cycles
    req_ready_i = 1'b0;
    cmd_ok("cmd_write_10", 2'd2, 7'h10, 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("req_valid_held", {63'd0, req_valid_o}, 64'd1);
      check("req_payload_held", {23'd0, req_addr_o, req_data_o, req_op_o},
            {23'd0, 7'h10, 32'h1, 2'd2});
      sri_rd("status_busy", 1, 64'h0000_0100_0000_0C82, 1'b0);
    end
    check("req_valid_held6", {63'd0, req_valid_o}, 64'd1);
    req_ready_i = 1'b1;
    cyc();
    check("req_valid_fall", {63'd0, req_valid_o}, 64'd0);

    // Second CMD while waiting for the response
    sri_wr("cmd_while_busy", 0, 64'h0000_0105_0000_0000, 8'hFF, 1'b1);
    sri_rd("status_busyerr", 1, 64'h0000_0300_0000_0C82, 1'b0);
    sri_wr("status_clear", 1, 64'h0000_0200_0000_0000, 8'hFF, 1'b0);
    sri_rd("status_cleared", 1, 64'h0000_0100_0000_0C82, 1'b0);
    do_resp("resp2", 32'h0000_1234, 2'd0);
    sri_rd("status2", 1, 64'h0000_0400_0000_1234, 1'b0);

    // Rejected accesses
    sri_wr("cmd_op3", 0, 64'h0000_0311_0000_0000, 8'hFF, 1'b1);
    sri_wr("cmd_op0", 0, 64'h0000_0011_0000_0000, 8'hFF, 1'b1);
    sri_wr("cmd_partial_be", 0, 64'h0000_0111_0000_0000, 8'h0F, 1'b1);
    sri_rd("read_word3", 3, 64'd0, 1'b1);
    cyc();
    sri_rd("status_unchanged", 1, 64'h0000_0400_0000_1234, 1'b0);

`ifdef SRI_DMI_TIMEOUT_EN
    cmd_ok("cmd_to", 2'd1, 7'h03, 32'd0);
    cyc();
    repeat (4) cyc();
    sri_rd("status_to_wait", 1, 64'h0000_0100_0000_1234, 1'b0);
    repeat (20) cyc();
    sri_rd("status_timeout", 1, 64'h0000_0D02_0000_1234, 1'b0);
    check("drain_ready", {63'd0, resp_ready_o}, 64'd1);
    sri_wr("cmd_during_drain", 0, 64'h0000_0107_0000_0000, 8'hFF, 1'b1);
    do_resp("late_resp", 32'h0000_FFFF, 2'd0);
    sri_rd("status_drained", 1, 64'h0000_0E02_0000_1234, 1'b0);
    sri_wr("status_clr_both", 1, 64'h0000_0A00_0000_0000, 8'hFF, 1'b0);
    cmd_ok("cmd_after_to", 2'd2, 7'h07, 32'h55);
    cyc();
    do_resp("resp3", 32'h0000_0077, 2'd0);
    sri_rd("status3", 1, 64'h0000_0400_0000_0077, 1'b0);
`endif

    // Reset in the middle of a transaction
    cmd_ok("cmd_rst", 2'd1, 7'h02, 32'd0);
    cyc();
    cyc();
    check("wait_resp_ready", {63'd0, resp_ready_o}, 64'd1);
    rst_i = 1'b1;
    cyc();
    check_all_zero("mid_reset");
    rst_i = 1'b0;
    sri_rd("status_after_mid_reset", 1, 64'd0, 1'b0);
    cyc();
    cyc();

    check("sri_queue_drained", 64'(exp_name_q.size()), 64'd0);
    check("req_queue_drained", 64'(exp_raddr_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
